// File: rtl/mux_pkg.sv
// mux_pkg -- shared definitions for the N:1 stream multiplexer.
// Contents:
//   MODE_MAN / MODE_RR : encodings of the 'mode' input (manual select / round-robin)
//   clog2()            : ceiling log2, used to size channel-index fields
// The round-robin feature that consumes MODE_RR is built only when macro
// MUX_RR_EN is defined (see mux_nx1_stream).
package mux_pkg;

  localparam logic MODE_MAN = 1'b0;
  localparam logic MODE_RR  = 1'b1;

  // Smallest r with 2**r >= value; callers only pass value >= 2.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int k = 0; k < 31; k++) begin
      if ((32'd1 << k) < 32'(value)) begin
        result = k + 1;
      end else begin
        result = result;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter -- combinational rotating-priority arbiter.
// Searches req[ptr], req[ptr+1], ... (mod N) and grants the first set bit.
// Ports:
//   req     [N-1:0]  : request vector
//   ptr     [SW-1:0] : channel with highest priority this cycle (must be < N)
//   gnt_idx [SW-1:0] : granted channel index (0 when gnt_any = 0)
//   gnt_any          : at least one request present
module rr_arbiter
  import mux_pkg::*;
#(
  parameter  int N  = 4,
  localparam int SW = clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic [SW-1:0] gnt_idx,
  output logic          gnt_any
);

  localparam logic [SW:0] N_EXT = (SW+1)'(N);

  logic [SW:0] cand_s;

  // Priority search: offsets are walked from farthest to nearest so the
  // candidate closest to ptr is the last one written and therefore wins.
  always_comb begin
    gnt_idx = {SW{1'b0}};
    gnt_any = 1'b0;
    cand_s  = {(SW+1){1'b0}};
    for (int off = N - 1; off >= 0; off--) begin
      cand_s = {1'b0, ptr} + (SW+1)'(off);
      if (cand_s >= N_EXT) begin
        cand_s = cand_s - N_EXT;
      end else begin
        cand_s = cand_s;
      end
      if (req[cand_s[SW-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = cand_s[SW-1:0];
      end else begin
        gnt_any = gnt_any;
      end
    end
  end

endmodule

// File: rtl/mux_nx1_stream.sv
// mux_nx1_stream -- N-input valid/ready stream multiplexer with a one-entry
// registered output stage (full throughput: a new word loads whenever the
// stage is empty or being consumed in the same cycle).
// Ports:
//   clk, rst          : rising-edge clock, synchronous active-high reset
//   i       [N*W-1:0] : channel k data in bits [k*W +: W]
//   i_valid [N-1:0]   : channel k valid
//   i_ready [N-1:0]   : channel k accepted this cycle (one-hot or zero)
//   s       [SW-1:0]  : manual channel select (values >= N grant nothing)
//   mode              : MODE_MAN / MODE_RR (present only with MUX_RR_EN)
//   y       [W-1:0]   : registered selected data
//   y_valid           : y holds an unconsumed word
//   y_ready           : downstream accepts y
//   y_sel   [SW-1:0]  : source channel of y
// Build option: define MUX_RR_EN to add the mode port, the rotating pointer
// and the round-robin arbiter; otherwise the block is manual-select only.
module mux_nx1_stream
  import mux_pkg::*;
#(
  parameter  int W  = 8,
  parameter  int N  = 4,
  localparam int SW = clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N*W-1:0] i,
  input  logic [N-1:0]   i_valid,
  output logic [N-1:0]   i_ready,
  input  logic [SW-1:0]  s,
`ifdef MUX_RR_EN
  input  logic           mode,
`endif
  output logic [W-1:0]   y,
  output logic           y_valid,
  input  logic           y_ready,
  output logic [SW-1:0]  y_sel
);

  logic          load_s;
  logic          man_any_s;
  logic [SW-1:0] man_idx_s;
  logic          gnt_any_s;
  logic [SW-1:0] gnt_idx_s;
  logic          xfer_s;
  logic [W-1:0]  sel_data_s;
  logic [W-1:0]  y_r;
  logic [SW-1:0] y_sel_r;
  logic          y_valid_r;

`ifdef MUX_RR_EN
  logic [SW-1:0] ptr_r;
  logic [SW-1:0] ptr_next_s;
  logic [SW-1:0] rr_idx_s;
  logic          rr_any_s;

  rr_arbiter #(.N(N)) u_rr_arbiter (
    .req     (i_valid),
    .ptr     (ptr_r),
    .gnt_idx (rr_idx_s),
    .gnt_any (rr_any_s)
  );
`endif

  assign load_s = !y_valid_r || y_ready;

  // Manual grant: matching s against each real channel means an
  // out-of-range select simply finds no match.
  always_comb begin
    man_any_s = 1'b0;
    man_idx_s = {SW{1'b0}};
    for (int k = 0; k < N; k++) begin
      if ((s == SW'(k)) && i_valid[k]) begin
        man_any_s = 1'b1;
        man_idx_s = SW'(k);
      end else begin
        man_any_s = man_any_s;
      end
    end
  end

  // Grant source selection between manual and round-robin.
  always_comb begin
    gnt_any_s = man_any_s;
    gnt_idx_s = man_idx_s;
`ifdef MUX_RR_EN
    if (mode == MODE_RR) begin
      gnt_any_s = rr_any_s;
      gnt_idx_s = rr_idx_s;
    end else begin
      gnt_any_s = man_any_s;
      gnt_idx_s = man_idx_s;
    end
`endif
  end

  // Reset blocks transfers so i_ready stays low while rst is asserted.
  assign xfer_s = gnt_any_s && load_s && !rst;

  // Ready fan-out and data selection for the granted channel.
  always_comb begin
    i_ready    = {N{1'b0}};
    sel_data_s = {W{1'b0}};
    for (int k = 0; k < N; k++) begin
      i_ready[k] = xfer_s && (gnt_idx_s == SW'(k));
      sel_data_s = (gnt_idx_s == SW'(k)) ? i[k*W +: W] : sel_data_s;
    end
  end

  // Output stage: load on transfer, drain on consume, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_r       <= {W{1'b0}};
      y_sel_r   <= {SW{1'b0}};
      y_valid_r <= 1'b0;
    end else if (xfer_s) begin
      y_r       <= sel_data_s;
      y_sel_r   <= gnt_idx_s;
      y_valid_r <= 1'b1;
    end else if (y_ready) begin
      y_valid_r <= 1'b0;
    end else begin
      y_valid_r <= y_valid_r;
    end
  end

`ifdef MUX_RR_EN
  assign ptr_next_s = (gnt_idx_s == SW'(N - 1)) ? {SW{1'b0}} : (gnt_idx_s + SW'(1'b1));

  // Rotating priority pointer; moves past the winner on round-robin transfers only.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r <= {SW{1'b0}};
    end else if (xfer_s && (mode == MODE_RR)) begin
      ptr_r <= ptr_next_s;
    end else begin
      ptr_r <= ptr_r;
    end
  end
`endif

  assign y       = y_r;
  assign y_valid = y_valid_r;
  assign y_sel   = y_sel_r;

endmodule

// File: tb/tb_mux_nx1_stream.sv
// tb_mux_nx1_stream -- self-checking bench for mux_nx1_stream.
// Instance dut (W=8, N=4) is compared cycle by cycle against a transaction
// model; instance dut3 (W=8, N=3) covers the out-of-range select.
// Round-robin steps are compiled only when MUX_RR_EN is defined.
module tb_mux_nx1_stream;

  localparam int W = 8;
  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] i_d;
  logic [3:0]  iv;
  logic [3:0]  ir;
  logic [1:0]  s_d;
  logic        mode_d;
  logic [7:0]  y;
  logic        yv;
  logic        yr;
  logic [1:0]  ysel;

  logic [23:0] i3;
  logic [2:0]  iv3;
  logic [2:0]  ir3;
  logic [1:0]  s3;
  logic        mode3;
  logic [7:0]  y3;
  logic        yv3;
  logic        yr3;
  logic [1:0]  ysel3;

  int n_checks = 0;
  int n_pass   = 0;

  // transaction model state
  logic [7:0] m_y;
  logic [1:0] m_sel;
  logic       m_valid;
  int         m_ptr;
  logic [3:0] ir_seen;

  mux_nx1_stream #(.W(W), .N(N)) dut (
    .clk(clk), .rst(rst), .i(i_d), .i_valid(iv), .i_ready(ir), .s(s_d),
`ifdef MUX_RR_EN
    .mode(mode_d),
`endif
    .y(y), .y_valid(yv), .y_ready(yr), .y_sel(ysel)
  );

  mux_nx1_stream #(.W(8), .N(3)) dut3 (
    .clk(clk), .rst(rst), .i(i3), .i_valid(iv3), .i_ready(ir3), .s(s3),
`ifdef MUX_RR_EN
    .mode(mode3),
`endif
    .y(y3), .y_valid(yv3), .y_ready(yr3), .y_sel(ysel3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: apply inputs, check i_ready against the model, clock, check outputs.
  task automatic drive(input logic [31:0] din, input logic [3:0] v, input logic [1:0] sv,
                       input logic md, input logic yrdy, input logic r);
    logic md_eff;
    bit   gnt;
    int   g;
    logic [3:0] exp_rdy;
    bit   load;
`ifdef MUX_RR_EN
    md_eff = md;
`else
    md_eff = 1'b0;
`endif
    i_d = din; iv = v; s_d = sv; mode_d = md; yr = yrdy; rst = r;
    #1;
    gnt = 0;
    g   = 0;
    if (!md_eff) begin
      if (int'(sv) < N && v[sv]) begin
        gnt = 1;
        g   = int'(sv);
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (!gnt && v[c]) begin
          gnt = 1;
          g   = c;
        end
      end
    end
    load    = !m_valid || yrdy;
    exp_rdy = (!r && gnt && load) ? (4'b0001 << g) : 4'b0000;
    ir_seen = ir;
    check("i_ready", ir, exp_rdy);
    @(posedge clk);
    #1;
    if (r) begin
      m_y = 8'h00; m_sel = 2'd0; m_valid = 1'b0; m_ptr = 0;
    end else if (gnt && load) begin
      m_y = din[g*8 +: 8];
      m_sel = 2'(g);
      m_valid = 1'b1;
      if (md_eff) m_ptr = (g + 1) % N;
    end else if (yrdy) begin
      m_valid = 1'b0;
    end
    check("y", y, m_y);
    check("y_valid", yv, m_valid);
    check("y_sel", ysel, m_sel);
  endtask

  initial begin
    rst = 1'b1; i_d = 32'h0; iv = 4'h0; s_d = 2'd0; mode_d = 1'b0; yr = 1'b1;
    i3 = 24'h0; iv3 = 3'b000; s3 = 2'd0; mode3 = 1'b0; yr3 = 1'b1;
    m_y = 8'h00; m_sel = 2'd0; m_valid = 1'b0; m_ptr = 0; ir_seen = 4'h0;
    @(posedge clk);
    #1;

    // reset state
    drive(32'h0, 4'b0000, 2'd0, 1'b0, 1'b1, 1'b1);
    check("rst_y", y, 8'h00);
    check("rst_vld", yv, 1'b0);
    drive(32'h0, 4'b0000, 2'd0, 1'b0, 1'b1, 1'b0);

    // out-of-range select on the N=3 instance
    i3 = 24'h33_22_11; iv3 = 3'b111; s3 = 2'd3; yr3 = 1'b1;
    #1;
    check("oor_rdy", ir3, 3'b000);
    @(posedge clk); #1;
    check("oor_vld", yv3, 1'b0);
    s3 = 2'd2;
    #1;
    check("n3_rdy", ir3, 3'b100);
    @(posedge clk); #1;
    check("n3_vld", yv3, 1'b1);
    check("n3_y", y3, 8'h33);
    check("n3_sel", ysel3, 2'd2);
    iv3 = 3'b000; s3 = 2'd0;

    // manual select
    drive(32'h00A5_0000, 4'b0100, 2'd2, 1'b0, 1'b1, 1'b0);
    check("man_rdy", ir_seen, 4'b0100);
    check("man_y", y, 8'hA5);
    check("man_sel", ysel, 2'd2);
    check("man_vld", yv, 1'b1);

    // backpressure
    repeat (3) begin
      drive(32'h003C_0000, 4'b0100, 2'd2, 1'b0, 1'b0, 1'b0);
      check("bp_rdy", ir_seen, 4'b0000);
      check("bp_y", y, 8'hA5);
    end
    drive(32'h003C_0000, 4'b0100, 2'd2, 1'b0, 1'b1, 1'b0);
    check("bp_rel_rdy", ir_seen, 4'b0100);
    check("bp_rel_y", y, 8'h3C);
    drive(32'h0, 4'b0000, 2'd2, 1'b0, 1'b1, 1'b0);
    check("drain_vld", yv, 1'b0);

    // reset mid-operation
    drive(32'h0077_0000, 4'b0100, 2'd2, 1'b0, 1'b0, 1'b0);
    check("pre_rst_vld", yv, 1'b1);
    drive(32'h0077_0000, 4'b0100, 2'd2, 1'b0, 1'b0, 1'b1);
    check("mid_rst_rdy", ir_seen, 4'b0000);
    check("mid_rst_y", y, 8'h00);
    check("mid_rst_vld", yv, 1'b0);

`ifdef MUX_RR_EN
    // round-robin sequence 0,1,2,3,0 (ptr starts at 0 after reset)
    for (int k = 0; k < 5; k++) begin
      drive(32'h4433_2211, 4'b1111, 2'd0, 1'b1, 1'b1, 1'b0);
      check("rr_seq", ysel, 32'(k % 4));
      check("rr_y", y, 32'(8'h11 * (k % 4 + 1)));
    end
    // ptr=1: grant 2 -> ptr=3; sparse 0010 -> grant 1 -> ptr=2
    drive(32'h4433_2211, 4'b0100, 2'd0, 1'b1, 1'b1, 1'b0);
    check("rr_to3", ysel, 2'd2);
    drive(32'h4433_2211, 4'b0010, 2'd0, 1'b1, 1'b1, 1'b0);
    check("rr_sparse", ysel, 2'd1);
    drive(32'h4433_2211, 4'b1111, 2'd0, 1'b1, 1'b1, 1'b0);
    check("rr_ptr2", ysel, 2'd2);
    // manual transfer must not move ptr (still 3)
    drive(32'h4433_2211, 4'b1111, 2'd0, 1'b0, 1'b1, 1'b0);
    check("man_in_rr", ysel, 2'd0);
    drive(32'h4433_2211, 4'b1111, 2'd0, 1'b1, 1'b1, 1'b0);
    check("rr_ptr_hold", ysel, 2'd3);
    // reset returns ptr to 0
    drive(32'h4433_2211, 4'b1111, 2'd0, 1'b1, 1'b1, 1'b1);
    drive(32'h4433_2211, 4'b1111, 2'd0, 1'b1, 1'b1, 1'b0);
    check("rr_after_rst", ysel, 2'd0);
`endif

    // randomized traffic against the model
    for (int n = 0; n < 300; n++) begin
      drive($urandom, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 39) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
